// File: rtl/ysyx_22040895_ifu_fq.sv
// ---------------------------------------------------------------------------
// ysyx_22040895_ifu_fq
//   Instruction fetch unit with an in-order fetch queue. It owns the fetch PC,
//   issues pipelined valid/ready requests to instruction memory (at most
//   MAX_OUTST in flight), buffers in-order responses as {pc, inst} pairs in a
//   FETCH_DEPTH-entry queue, and hands the queue head to the decoder over a
//   valid/ready handshake. A redirect flushes the queue and squashes every
//   response still in flight.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   pcsel_i, dnpc_i          one-cycle redirect strobe and target (bits [1:0] ignored)
//   req_valid_o/ready_i      memory request handshake, req_addr_o = fetch PC
//   resp_valid_i, resp_inst_i in-order memory response (always consumed)
//   inst_valid_o/ready_i     queue head handshake to the decoder
//   inst_o, pc_o             queue head instruction and PC
//   ce_o                     fetch enable, low in reset and the first cycle after
// ---------------------------------------------------------------------------

// Protocol checks kept apart from the datapath.
module ysyx_22040895_ifu_fq_chk #(
    parameter int OUT_W       = 2,
    parameter int CNT_W       = 3,
    parameter int FETCH_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             resp_valid,
    input  logic [OUT_W-1:0] outst,
    input  logic [CNT_W-1:0] count
);

    resp_no_outst_a: assert property (@(posedge clk) disable iff (!rst)
        resp_valid |-> (outst != {OUT_W{1'b0}}));

    count_bound_a: assert property (@(posedge clk) disable iff (!rst)
        (32'(count) <= 32'(FETCH_DEPTH)));

endmodule

module ysyx_22040895_ifu_fq #(
    parameter int                ADDR_W      = 64,
    parameter int                INST_W      = 32,
    parameter int                FETCH_DEPTH = 4,
    parameter int                MAX_OUTST   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(32'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pcsel_i,
    input  logic [ADDR_W-1:0] dnpc_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              resp_valid_i,
    input  logic [INST_W-1:0] resp_inst_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o
);

    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam int PTR_W = $clog2(FETCH_DEPTH);
    localparam int CNT_W = $clog2(FETCH_DEPTH + 1);

    // Registered state
    logic              ce_r;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] resp_pc_r;
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic [OUT_W-1:0]  outst_r;
    logic [OUT_W-1:0]  drop_r;
    logic [ADDR_W-1:0] q_pc_r   [FETCH_DEPTH];
    logic [INST_W-1:0] q_inst_r [FETCH_DEPTH];

    // Next-state and handshake signals
    logic              req_hs_s;
    logic              pop_s;
    logic              push_s;
    logic              wr_en_s;
    logic              credit_s;
    logic [ADDR_W-1:0] target_s;
    logic [ADDR_W-1:0] fetch_pc_n_s;
    logic [ADDR_W-1:0] resp_pc_n_s;
    logic [PTR_W-1:0]  head_n_s;
    logic [PTR_W-1:0]  tail_n_s;
    logic [CNT_W-1:0]  count_n_s;
    logic [OUT_W-1:0]  outst_n_s;
    logic [OUT_W-1:0]  drop_n_s;

    // A request is only issued when the response is guaranteed a queue slot:
    // every in-flight request plus every buffered entry must fit in the queue.
    assign credit_s = (32'(outst_r) < 32'(MAX_OUTST)) &&
                      ((32'(outst_r) + 32'(count_r)) < 32'(FETCH_DEPTH));

    assign req_valid_o  = ce_r & credit_s;
    assign req_addr_o   = fetch_pc_r;
    assign ce_o         = ce_r;
    assign inst_valid_o = (count_r != {CNT_W{1'b0}});
    // Head fields come straight from the queue flops; the head slot is never
    // rewritten while it is still waiting to be popped.
    assign inst_o       = q_inst_r[head_r];
    assign pc_o         = q_pc_r[head_r];

    assign req_hs_s = req_valid_o & req_ready_i;
    assign pop_s    = inst_valid_o & inst_ready_i;
    assign push_s   = resp_valid_i & (drop_r == {OUT_W{1'b0}});
    assign wr_en_s  = push_s & ~pcsel_i;
    assign target_s = {dnpc_i[ADDR_W-1:2], 2'b00};

    // Next-state for PCs, queue pointers and the outstanding/drop counters.
    always_comb begin
        fetch_pc_n_s = fetch_pc_r;
        resp_pc_n_s  = resp_pc_r;
        head_n_s     = head_r;
        tail_n_s     = tail_r;
        count_n_s    = count_r;
        drop_n_s     = drop_r;
        // Requests issued minus responses returned, redirect or not.
        outst_n_s    = outst_r + OUT_W'(req_hs_s) - OUT_W'(resp_valid_i);

        if (pcsel_i) begin
            // Everything still in flight after this cycle (including a request
            // accepted right now) belongs to the old path and is squashed.
            fetch_pc_n_s = target_s;
            resp_pc_n_s  = target_s;
            head_n_s     = {PTR_W{1'b0}};
            tail_n_s     = {PTR_W{1'b0}};
            count_n_s    = {CNT_W{1'b0}};
            drop_n_s     = outst_n_s;
        end else begin
            if (req_hs_s) begin
                fetch_pc_n_s = fetch_pc_r + ADDR_W'(3'd4);
            end else begin
                fetch_pc_n_s = fetch_pc_r;
            end

            if (resp_valid_i) begin
                if (drop_r != {OUT_W{1'b0}}) begin
                    drop_n_s = drop_r - OUT_W'(1'b1);
                end else begin
                    resp_pc_n_s = resp_pc_r + ADDR_W'(3'd4);
                    tail_n_s    = tail_r + PTR_W'(1'b1);
                end
            end else begin
                drop_n_s = drop_r;
            end

            if (pop_s) begin
                head_n_s = head_r + PTR_W'(1'b1);
            end else begin
                head_n_s = head_r;
            end

            count_n_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_r       <= 1'b0;
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            outst_r    <= {OUT_W{1'b0}};
            drop_r     <= {OUT_W{1'b0}};
        end else begin
            ce_r       <= 1'b1;
            fetch_pc_r <= fetch_pc_n_s;
            resp_pc_r  <= resp_pc_n_s;
            head_r     <= head_n_s;
            tail_r     <= tail_n_s;
            count_r    <= count_n_s;
            outst_r    <= outst_n_s;
            drop_r     <= drop_n_s;
        end
    end

    // Queue storage: write the accepted response at the tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_pc_r   <= '{default: {ADDR_W{1'b0}}};
            q_inst_r <= '{default: {INST_W{1'b0}}};
        end else if (wr_en_s) begin
            q_pc_r[tail_r]   <= resp_pc_r;
            q_inst_r[tail_r] <= resp_inst_i;
        end
    end

    ysyx_22040895_ifu_fq_chk #(
        .OUT_W       (OUT_W),
        .CNT_W       (CNT_W),
        .FETCH_DEPTH (FETCH_DEPTH)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .resp_valid (resp_valid_i),
        .outst      (outst_r),
        .count      (count_r)
    );

endmodule
